gray_step_decoder: RTL and testbench

- Receive-side counterpart of the team's gray-coded counters.
- Samples a WIDTH-bit reflected-binary gray code on qualified cycles and converts it to binary.
- Classifies each new sample against the previous one as hold, up-step, down-step or illegal jump, and tracks lock status and a saturating error count.
- Sits between a gray-coded position/pointer source and control logic that needs binary values plus step events.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray_to_bin.sv | 17 +
 rtl/gray_step_decoder.sv | 122 ++++++++++++
 tb/tb_gray_step_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for gray-domain blocks: decoder state encoding and a gray-to-binary helper.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_SUSPECT  = 2'd2
  } state_e;

  // Each binary bit is the XOR of its gray bit and all more-significant gray bits.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int unsigned i = 1; i < GRAY_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational reflected-binary gray to binary converter.
module gray_to_bin #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    bin_o[WIDTH-1] = gray_i[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/gray_step_decoder.sv
// Samples a gray code, converts it to binary and classifies each sample as hold/up/down/illegal,
// with lock tracking and a saturating error counter.
module gray_step_decoder
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 sample_en,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 step_up,
  output logic                 step_dn,
  output logic                 step_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic                 up_q, up_d;
  logic                 dn_q, dn_d;
  logic                 err_q, err_d;
  logic                 locked_q, locked_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]     new_bin_c;
  logic [WIDTH-1:0]     diff_c;
  logic                 is_up_c, is_dn_c, is_err_c;

  gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
    .gray_i (gray_in),
    .bin_o  (new_bin_c)
  );

  // Modular difference against the last accepted value.
  assign diff_c   = new_bin_c - bin_q;
  assign is_up_c  = (diff_c == WIDTH'(1));
  assign is_dn_c  = (diff_c == '1);
  assign is_err_c = (diff_c != '0) && !is_up_c && !is_dn_c;

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    up_d     = 1'b0;
    dn_d     = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
    if (sample_en) begin
      bin_d = new_bin_c;
      unique case (state_q)
        ST_UNLOCKED: begin
          state_d  = ST_LOCKED;
          locked_d = 1'b1;
        end
        ST_LOCKED: begin
          if (is_err_c) begin
            err_d   = 1'b1;
            state_d = ST_SUSPECT;
          end else begin
            up_d = is_up_c;
            dn_d = is_dn_c;
          end
        end
        ST_SUSPECT: begin
          if (is_err_c) begin
            err_d    = 1'b1;
            state_d  = ST_UNLOCKED;
            locked_d = 1'b0;
          end else begin
            up_d    = is_up_c;
            dn_d    = is_dn_c;
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d  = ST_UNLOCKED;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // Clear applies first so an error in the same cycle is still counted.
  always_comb begin
    err_cnt_d = clr_err ? '0 : err_cnt_q;
    if (err_d && (err_cnt_d != '1)) begin
      err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_UNLOCKED;
      bin_q     <= '0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bin_out  = bin_q;
  assign step_up  = up_q;
  assign step_dn  = dn_q;
  assign step_err = err_q;
  assign locked   = locked_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Directed bench for gray_step_decoder: a reference model pushes expectations to a queue,
// popped and compared one cycle after each driven sample.
module tb_gray_step_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] gray_in;
  logic       sample_en;
  logic       clr_err;

  logic [2:0] bin_out, bin_out2;
  logic       step_up, step_dn, step_err, locked;
  logic       step_up2, step_dn2, step_err2, locked2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] bin;
    logic       up;
    logic       dn;
    logic       err;
    logic       lk;
    logic [7:0] ec8;
    logic [1:0] ec2;
  } exp_t;

  exp_t exp_q[$];

  int         m_state;   // 0 unlocked, 1 locked, 2 suspect
  logic [2:0] m_bin;
  int         m_ec8;
  int         m_ec2;

  always #5 clk = ~clk;

  gray_step_decoder #(.WIDTH(3), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .sample_en(sample_en), .clr_err(clr_err),
    .bin_out(bin_out), .step_up(step_up), .step_dn(step_dn), .step_err(step_err),
    .locked(locked), .err_cnt(err_cnt)
  );

  gray_step_decoder #(.WIDTH(3), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .sample_en(sample_en), .clr_err(clr_err),
    .bin_out(bin_out2), .step_up(step_up2), .step_dn(step_dn2), .step_err(step_err2),
    .locked(locked2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_bin   = 3'd0;
    m_ec8   = 0;
    m_ec2   = 0;
  endtask

  task automatic step(input logic [2:0] g, input logic en, input logic clr, input string tag);
    exp_t       e;
    exp_t       got;
    logic [2:0] nb;
    logic [2:0] d;
    logic       hold, up, dn, bad;
    gray_in   = g;
    sample_en = en;
    clr_err   = clr;
    nb = 3'd0;
    for (int k = 0; k < 3; k++) nb = nb ^ (g >> k);
    d    = 3'(nb - m_bin);
    hold = (d == 3'd0);
    up   = (d == 3'd1);
    dn   = (d == 3'd7);
    bad  = !(hold || up || dn);
    e = '0;
    if (clr) begin
      m_ec8 = 0;
      m_ec2 = 0;
    end
    if (en) begin
      if (m_state == 0) begin
        m_state = 1;
      end else if (bad) begin
        e.err   = 1'b1;
        m_state = (m_state == 1) ? 2 : 0;
      end else begin
        e.up    = up;
        e.dn    = dn;
        m_state = 1;
      end
      m_bin = nb;
    end
    if (e.err) begin
      if (m_ec8 < 255) m_ec8++;
      if (m_ec2 < 3)   m_ec2++;
    end
    e.bin = m_bin;
    e.lk  = (m_state != 0);
    e.ec8 = 8'(m_ec8);
    e.ec2 = 2'(m_ec2);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      chk({tag, ".bin"},  32'(bin_out),  32'(got.bin));
      chk({tag, ".up"},   32'(step_up),  32'(got.up));
      chk({tag, ".dn"},   32'(step_dn),  32'(got.dn));
      chk({tag, ".err"},  32'(step_err), 32'(got.err));
      chk({tag, ".lk"},   32'(locked),   32'(got.lk));
      chk({tag, ".ec8"},  32'(err_cnt),  32'(got.ec8));
      chk({tag, ".ec2"},  32'(err_cnt2), 32'(got.ec2));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".bin"}, 32'(bin_out),  32'd0);
    chk({tag, ".up"},  32'(step_up),  32'd0);
    chk({tag, ".dn"},  32'(step_dn),  32'd0);
    chk({tag, ".err"}, 32'(step_err), 32'd0);
    chk({tag, ".lk"},  32'(locked),   32'd0);
    chk({tag, ".ec8"}, 32'(err_cnt),  32'd0);
    chk({tag, ".ec2"}, 32'(err_cnt2), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    gray_in   = 3'b000;
    sample_en = 1'b0;
    clr_err   = 1'b0;
    model_reset();
    #12;
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Lock on 000, then a full upward sweep with wrap.
    step(3'b000, 1'b1, 1'b0, "lock0");
    step(3'b001, 1'b1, 1'b0, "up1");
    step(3'b011, 1'b1, 1'b0, "up2");
    step(3'b010, 1'b1, 1'b0, "up3");
    step(3'b110, 1'b1, 1'b0, "up4");
    step(3'b111, 1'b1, 1'b0, "up5");
    step(3'b101, 1'b1, 1'b0, "up6");
    step(3'b100, 1'b1, 1'b0, "up7");
    step(3'b000, 1'b1, 1'b0, "wrap_up");
    chk("wrap_bin_const", 32'(bin_out), 32'd0);

    // Downward wrap, hold, and ignored samples.
    step(3'b100, 1'b1, 1'b0, "wrap_dn");
    chk("wrap_dn_const", 32'(bin_out), 32'd7);
    step(3'b100, 1'b1, 1'b0, "hold");
    step(3'b011, 1'b0, 1'b0, "ign_a");
    step(3'b010, 1'b0, 1'b0, "ign_b");
    step(3'b101, 1'b1, 1'b0, "dn6");
    step(3'b100, 1'b1, 1'b0, "up7b");
    step(3'b000, 1'b1, 1'b0, "to0");

    // Illegal jumps: LOCKED -> SUSPECT -> LOCKED -> SUSPECT -> UNLOCKED -> relock.
    step(3'b010, 1'b1, 1'b0, "err_1bit");
    chk("err_1bit_bin", 32'(bin_out), 32'd3);
    step(3'b110, 1'b1, 1'b0, "suspect_up");
    step(3'b000, 1'b1, 1'b0, "err2");
    step(3'b101, 1'b1, 1'b0, "err3_unlock");
    chk("unlock_const", 32'(locked), 32'd0);
    step(3'b100, 1'b1, 1'b0, "relock");

    // Saturation of the narrow counter and clear interactions.
    step(3'b100, 1'b0, 1'b1, "clr_pre");
    step(3'b110, 1'b1, 1'b0, "sat_e1");
    step(3'b000, 1'b1, 1'b0, "sat_e2");
    step(3'b110, 1'b1, 1'b0, "sat_load");
    step(3'b000, 1'b1, 1'b0, "sat_e3");
    step(3'b110, 1'b1, 1'b0, "sat_e4");
    step(3'b000, 1'b1, 1'b0, "sat_load2");
    step(3'b110, 1'b1, 1'b0, "sat_e5");
    chk("sat_const", 32'(err_cnt2), 32'd3);
    step(3'b000, 1'b1, 1'b1, "clr_with_err");
    chk("clr_err_const", 32'(err_cnt2), 32'd1);
    step(3'b000, 1'b0, 1'b1, "clr_alone");
    chk("clr_alone_const", 32'(err_cnt), 32'd0);

    // Asynchronous reset between edges mid-sweep.
    step(3'b000, 1'b1, 1'b0, "pre_rst_lock");
    step(3'b001, 1'b1, 1'b0, "pre_rst_up");
    sample_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3'b011, 1'b1, 1'b0, "post_rst");
    chk("post_rst_const", 32'(bin_out), 32'd2);
    step(3'b010, 1'b1, 1'b0, "post_rst_up");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
